// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RV32I core: owns the PC, issues one instruction-memory
// read at a time, holds the returned word for decode and accepts redirects
// from execute.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned-redirect trap
// with S_FAULT state and fetch_misalign output). Without it, redirect targets
// are forced word-aligned.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        decode_ready,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [6:0]  opcode,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_FAULT = 3'd4
`endif
    } state_t;

    state_t      state;
    state_t      redir_state_c;
    logic [31:0] pc;
    logic [31:0] redirect_pc_c;
    logic        handshake_c;
    logic        in_flight_c;
    logic        misalign_c;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_drain;
`endif

    assign imem_addr   = pc;
    assign opcode      = instruction[6:0];
    assign pc_plus4    = instr_pc + 32'd4;
    assign handshake_c = (state == S_REQ) && imem_req_valid && imem_req_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_pc_c = redirect_target;
    assign misalign_c    = |redirect_target[1:0];
`else
    // Low target bits are dropped: the PC is always word aligned.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target[1:0];
    assign redirect_pc_c      = {redirect_target[31:2], 2'b00};
    assign misalign_c         = 1'b0;
`endif

    // A request is still owed a response after this cycle if we redirect now.
    always_comb begin
        in_flight_c = 1'b0;
        case (state)
            S_REQ:   in_flight_c = handshake_c;
            S_WAIT:  in_flight_c = !imem_rsp_valid;
            S_DRAIN: in_flight_c = !imem_rsp_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
            S_FAULT: in_flight_c = fault_drain && !imem_rsp_valid;
`endif
            default: in_flight_c = 1'b0;
        endcase
    end

    // Destination state on a redirect; a response landing in the same cycle
    // as a redirect in S_DRAIN retires the drain rather than waiting forever.
    always_comb begin
        redir_state_c = in_flight_c ? S_DRAIN : S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misalign_c) begin
            redir_state_c = S_FAULT;
        end
`endif
    end

    // Fetch FSM with registered request, instruction and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instruction    <= NOP_INSTR;
            instr_pc       <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misalign <= 1'b0;
            fault_drain    <= 1'b0;
`endif
        end else if (redirect_valid) begin
            state          <= redir_state_c;
            pc             <= redirect_pc_c;
            imem_req_valid <= (redir_state_c == S_REQ);
            instr_valid    <= 1'b0;
            instruction    <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misalign <= misalign_c;
            fault_drain    <= misalign_c && in_flight_c;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (!imem_req_valid) begin
                        imem_req_valid <= 1'b1;
                    end else if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        instruction <= imem_rsp_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (decode_ready) begin
                        pc             <= pc + 32'd4;
                        instr_valid    <= 1'b0;
                        instruction    <= NOP_INSTR;
                        imem_req_valid <= 1'b1;
                        state          <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid) begin
                        imem_req_valid <= 1'b1;
                        state          <= S_REQ;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                S_FAULT: begin
                    if (imem_rsp_valid) begin
                        fault_drain <= 1'b0;
                    end
                end
`endif
                default: begin
                    imem_req_valid <= 1'b0;
                    instr_valid    <= 1'b0;
                    state          <= S_REQ;
                end
            endcase
        end
    end

endmodule
